// File: rtl/lfsr_pkg.sv
// Shared constants, form selector and maximal-length tap tables for the
// LFSR sequence generator.
package lfsr_pkg;

  localparam int LFSR_MIN_BITS = 3;
  localparam int LFSR_MAX_BITS = 32;

  // Feedback structure: external XOR chain or XOR gates inside the shift path.
  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_form_e;

  // Fibonacci tap mask: bit (t-1) set for every tap t of a primitive polynomial.
  function automatic logic [31:0] f_Taps_Fib(input int n);
    logic [31:0] taps;
    case (n)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

  // Galois mask for the same polynomial: the x^n term is implied by the MSB
  // feeding back, the lower coefficients move up one place and x^0 is always set.
  function automatic logic [31:0] f_Taps_Gal(input int n);
    logic [31:0] fib;
    logic [31:0] mask;
    fib  = f_Taps_Fib(n);
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    return ((fib << 1) & mask) | 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational next-state function of the LFSR for either feedback form.
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic [NUM_BITS-1:0] i_State,
  input  lfsr_form_e          i_Mode,
  input  logic [NUM_BITS-1:0] i_Taps_Fib,
  input  logic [NUM_BITS-1:0] i_Taps_Gal,
  output logic [NUM_BITS-1:0] o_Next
);

  logic w_Fb;

  // Shift left; new LSB is the tap parity (Fibonacci) or the MSB is folded into the taps (Galois).
  always_comb begin
    w_Fb = ^(i_State & i_Taps_Fib);
    if (i_Mode == LFSR_GAL) begin
      o_Next = {i_State[NUM_BITS-2:0], 1'b0} ^ ({NUM_BITS{i_State[NUM_BITS-1]}} & i_Taps_Gal);
    end else begin
      o_Next = {i_State[NUM_BITS-2:0], w_Fb};
    end
  end

endmodule

// File: rtl/lfsr_seq_gen.sv
// Maximal-length LFSR sequence generator with runtime seed load, zero-seed
// lock-up protection, wrap detection and period measurement.
module lfsr_seq_gen
  import lfsr_pkg::*;
#(
  parameter int                  NUM_BITS   = 8,
  parameter int                  GALOIS     = 0,
  parameter logic [NUM_BITS-1:0] SEED_RESET = NUM_BITS'(1)
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done,
  output logic                o_Lockup,
  output logic [NUM_BITS-1:0] o_Period
);

  generate
    if (NUM_BITS < LFSR_MIN_BITS || NUM_BITS > LFSR_MAX_BITS) begin : g_bad_width
      $error("lfsr_seq_gen: NUM_BITS=%0d outside %0d..%0d", NUM_BITS, LFSR_MIN_BITS, LFSR_MAX_BITS);
    end
    if (SEED_RESET == '0) begin : g_bad_seed
      $error("lfsr_seq_gen: SEED_RESET must be non-zero");
    end
  endgenerate

  localparam logic [31:0]         TAPS_FIB_ALL = f_Taps_Fib(NUM_BITS);
  localparam logic [31:0]         TAPS_GAL_ALL = f_Taps_Gal(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS_FIB     = TAPS_FIB_ALL[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] TAPS_GAL     = TAPS_GAL_ALL[NUM_BITS-1:0];
  localparam lfsr_form_e          FORM         = (GALOIS != 0) ? LFSR_GAL : LFSR_FIB;
  localparam logic [NUM_BITS-1:0] ONE          = NUM_BITS'(1);

  logic [NUM_BITS-1:0] r_LFSR;
  logic [NUM_BITS-1:0] r_Seed;
  logic [NUM_BITS-1:0] r_Count;
  logic [NUM_BITS-1:0] r_Period;
  logic                r_Done;
  logic                r_Lockup;

  logic [NUM_BITS-1:0] w_Next;
  logic [NUM_BITS-1:0] w_Seed_Fix;
  logic                w_Seed_Zero;
  logic                w_Wrap;

  lfsr_next_state #(
    .NUM_BITS (NUM_BITS)
  ) u_next_state (
    .i_State    (r_LFSR),
    .i_Mode     (FORM),
    .i_Taps_Fib (TAPS_FIB),
    .i_Taps_Gal (TAPS_GAL),
    .o_Next     (w_Next)
  );

  // A zero seed would freeze the register forever, so it is replaced by 1.
  always_comb begin
    w_Seed_Zero = (i_Seed_Data == '0);
    w_Seed_Fix  = w_Seed_Zero ? ONE : i_Seed_Data;
    w_Wrap      = (w_Next == r_Seed);
  end

  // State, seed, period counter and status pulses; seed load beats step beats hold.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_LFSR   <= SEED_RESET;
      r_Seed   <= SEED_RESET;
      r_Count  <= '0;
      r_Period <= '0;
      r_Done   <= 1'b0;
      r_Lockup <= 1'b0;
    end else if (i_Seed_DV) begin
      r_LFSR   <= w_Seed_Fix;
      r_Seed   <= w_Seed_Fix;
      r_Count  <= '0;
      r_Done   <= 1'b0;
      r_Lockup <= w_Seed_Zero;
    end else if (i_Enable) begin
      r_LFSR   <= w_Next;
      r_Lockup <= 1'b0;
      if (w_Wrap) begin
        r_Done   <= 1'b1;
        r_Period <= r_Count + ONE;
        r_Count  <= '0;
      end else begin
        r_Done   <= 1'b0;
        r_Count  <= r_Count + ONE;
      end
    end else begin
      r_Done   <= 1'b0;
      r_Lockup <= 1'b0;
    end
  end

  assign o_LFSR_Data = r_LFSR;
  assign o_LFSR_Done = r_Done;
  assign o_Lockup    = r_Lockup;
  assign o_Period    = r_Period;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Bench for lfsr_seq_gen: 4-bit Fibonacci and Galois instances driven in
// lock-step against a scoreboard, plus a free-running period sweep 3..16 bits.
module tb_lfsr_seq_gen;

  localparam int NSW = 28;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       rst_sweep_n = 1'b0;
  logic       en          = 1'b0;
  logic       dv          = 1'b0;
  logic [3:0] sd          = 4'h0;

  logic [3:0] f_data, f_per, g_data, g_per;
  logic       f_done, f_lock, g_done, g_lock;

  int n_checks   = 0;
  int n_errors   = 0;
  int sweep_fin  = 0;

  typedef struct packed {
    logic [3:0] data;
    logic       done;
    logic       lock;
    logic [3:0] per;
  } exp_t;

  exp_t q_fib[$];
  exp_t q_gal[$];

  logic [3:0] m_lfsr [2];
  logic [3:0] m_seed [2];
  logic [3:0] m_cnt  [2];
  logic [3:0] m_per  [2];

  logic [3:0] fib_tab [4] = '{4'h2, 4'h4, 4'h9, 4'h3};
  logic [3:0] gal_tab [5] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hB};

  always #5 clk = ~clk;

  lfsr_seq_gen #(.NUM_BITS(4), .GALOIS(0)) dut_fib (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Enable    (en),
    .i_Seed_DV   (dv),
    .i_Seed_Data (sd),
    .o_LFSR_Data (f_data),
    .o_LFSR_Done (f_done),
    .o_Lockup    (f_lock),
    .o_Period    (f_per)
  );

  lfsr_seq_gen #(.NUM_BITS(4), .GALOIS(1)) dut_gal (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Enable    (en),
    .i_Seed_DV   (dv),
    .i_Seed_Data (sd),
    .o_LFSR_Data (g_data),
    .o_LFSR_Done (g_done),
    .o_Lockup    (g_lock),
    .o_Period    (g_per)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference next state for x^4+x^3+1 in each form, written out bit by bit.
  function automatic logic [3:0] ref_next(input int k, input logic [3:0] s);
    if (k == 0) return {s[2:0], s[3] ^ s[2]};
    return s[3] ? ({s[2:0], 1'b0} ^ 4'b1001) : {s[2:0], 1'b0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = 4'h1;
      m_seed[k] = 4'h1;
      m_cnt[k]  = 4'h0;
      m_per[k]  = 4'h0;
    end
  endtask

  task automatic model_step(input int k, output exp_t e);
    logic [3:0] nx;
    e.done = 1'b0;
    e.lock = 1'b0;
    if (dv) begin
      nx = (sd == 4'h0) ? 4'h1 : sd;
      m_lfsr[k] = nx;
      m_seed[k] = nx;
      m_cnt[k]  = 4'h0;
      e.lock    = (sd == 4'h0);
    end else if (en) begin
      nx = ref_next(k, m_lfsr[k]);
      m_lfsr[k] = nx;
      if (nx == m_seed[k]) begin
        e.done   = 1'b1;
        m_per[k] = m_cnt[k] + 4'h1;
        m_cnt[k] = 4'h0;
      end else begin
        m_cnt[k] = m_cnt[k] + 4'h1;
      end
    end
    e.data = m_lfsr[k];
    e.per  = m_per[k];
  endtask

  // Drive one cycle of stimulus, queue the expectation, then compare after the edge.
  task automatic drive(input logic e_en, input logic e_dv, input logic [3:0] e_sd);
    exp_t ef, eg;
    en = e_en;
    dv = e_dv;
    sd = e_sd;
    model_step(0, ef);
    q_fib.push_back(ef);
    model_step(1, eg);
    q_gal.push_back(eg);
    @(posedge clk);
    #1;
    ef = q_fib.pop_front();
    eg = q_gal.pop_front();
    check_eq("fib data",   f_data, ef.data);
    check_eq("fib done",   f_done, ef.done);
    check_eq("fib lockup", f_lock, ef.lock);
    check_eq("fib period", f_per,  ef.per);
    check_eq("gal data",   g_data, eg.data);
    check_eq("gal done",   g_done, eg.done);
    check_eq("gal lockup", g_lock, eg.lock);
    check_eq("gal period", g_per,  eg.per);
  endtask

  // Period sweep: every width and form must wrap after exactly 2^N-1 steps.
  for (genvar g = 0; g < NSW; g++) begin : g_sw
    localparam int N = 3 + g / 2;
    localparam int G = g % 2;
    logic [N-1:0] w_data, w_per;
    logic         w_done, w_lock;

    lfsr_seq_gen #(.NUM_BITS(N), .GALOIS(G)) u_dut (
      .i_Clk       (clk),
      .i_Rst_L     (rst_sweep_n),
      .i_Enable    (1'b1),
      .i_Seed_DV   (1'b0),
      .i_Seed_Data ('0),
      .o_LFSR_Data (w_data),
      .o_LFSR_Done (w_done),
      .o_Lockup    (w_lock),
      .o_Period    (w_per)
    );

    initial begin
      int cyc;
      bit seen;
      cyc  = 0;
      seen = 1'b0;
      wait (rst_sweep_n === 1'b1);
      while (!seen && cyc < (1 << N) + 4) begin
        @(posedge clk);
        #1;
        cyc++;
        seen = w_done;
      end
      check_eq($sformatf("sweep N%0d G%0d done seen", N, G), 32'(seen), 32'd1);
      check_eq($sformatf("sweep N%0d G%0d steps", N, G), 32'(cyc), 32'((1 << N) - 1));
      check_eq($sformatf("sweep N%0d G%0d period", N, G), 32'(w_per), 32'((1 << N) - 1));
      check_eq($sformatf("sweep N%0d G%0d data", N, G), 32'(w_data), 32'd1);
      check_eq($sformatf("sweep N%0d G%0d lockup", N, G), 32'(w_lock), 32'd0);
      sweep_fin++;
    end
  end

  initial begin
    logic [3:0] held;
    int guard;
    model_reset();

    #12;
    check_eq("reset fib data",   f_data, 4'h1);
    check_eq("reset fib period", f_per,  4'h0);
    check_eq("reset fib done",   f_done, 1'b0);
    check_eq("reset fib lockup", f_lock, 1'b0);
    check_eq("reset gal data",   g_data, 4'h1);
    check_eq("reset gal period", g_per,  4'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    rst_sweep_n = 1'b1;

    // Free run from the reset seed: known opening values, wrap at step 15.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 4'h0);
      if (i < 4) check_eq("fib opening seq", f_data, fib_tab[i]);
      if (i < 5) check_eq("gal opening seq", g_data, gal_tab[i]);
      if (i == 14) begin
        check_eq("fib done step 15",   f_done, 1'b1);
        check_eq("gal done step 15",   g_done, 1'b1);
        check_eq("fib period first",   f_per,  4'd15);
        check_eq("gal period first",   g_per,  4'd15);
      end
    end

    // Zero seed is forced to 1 with a one-cycle lock-up pulse.
    drive(1'b0, 1'b1, 4'h0);
    check_eq("zero seed data", f_data, 4'h1);
    check_eq("zero seed lockup", f_lock, 1'b1);
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b0, 4'h0);
      if (i == 0) check_eq("lockup cleared", f_lock, 1'b0);
    end

    // Seed load wins over a simultaneous step and restarts the count.
    drive(1'b1, 1'b1, 4'h5);
    check_eq("seed priority fib", f_data, 4'h5);
    check_eq("seed priority gal", g_data, 4'h5);
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, 4'h0);
      if (i == 14) begin
        check_eq("reseed wrap data", f_data, 4'h5);
        check_eq("reseed wrap done", f_done, 1'b1);
      end
    end

    // Hold for seven cycles mid-sequence; the period must still read 15.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 4'h0);
    held = f_data;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 4'h0);
      check_eq("hold data", f_data, held);
    end
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 4'h0);
    check_eq("hold wrap done",   f_done, 1'b1);
    check_eq("hold wrap period", f_per,  4'd15);

    // Asynchronous reset between edges takes effect immediately.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async rst fib data",   f_data, 4'h1);
    check_eq("async rst fib period", f_per,  4'h0);
    check_eq("async rst gal data",   g_data, 4'h1);
    check_eq("async rst gal period", g_per,  4'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'h0);
    en = 1'b0;

    guard = 0;
    while (sweep_fin < NSW && guard < 70000) begin
      @(posedge clk);
      guard++;
    end
    check_eq("sweep instances finished", 32'(sweep_fin), 32'(NSW));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
